// File: rtl/ram_read_scheduler_if.sv
// Handshake/bus bundle for the RAM read scheduler.
// master = scheduler side, slave = RAM/consumer/status side.
interface ram_read_scheduler_if #(
  parameter int DATA_W = 36
);
  logic              buf_ready_i;
  logic [DATA_W-1:0] ram_data_i;
  logic              ram_valid_i;
  logic              ram_ready_o;
  logic              c0_req_i;
  logic              c1_req_i;
  logic [DATA_W-1:0] c0_data_o;
  logic [DATA_W-1:0] c1_data_o;
  logic              c0_valid_o;
  logic              c1_valid_o;
  logic              c0_ready_i;
  logic              c1_ready_i;
  logic              c0_last_o;
  logic              c1_last_o;
  logic [1:0]        grant_o;
  logic              busy_o;
  logic [15:0]       frame_count_o;
  logic [7:0]        drop_count_o;
  logic              overrun_o;
  logic              timeout_o;

  modport master (
    input  buf_ready_i, ram_data_i, ram_valid_i,
    input  c0_req_i, c1_req_i, c0_ready_i, c1_ready_i,
    output ram_ready_o,
    output c0_data_o, c1_data_o, c0_valid_o, c1_valid_o,
    output c0_last_o, c1_last_o,
    output grant_o, busy_o, frame_count_o, drop_count_o,
    output overrun_o, timeout_o
  );

  modport slave (
    output buf_ready_i, ram_data_i, ram_valid_i,
    output c0_req_i, c1_req_i, c0_ready_i, c1_ready_i,
    input  ram_ready_o,
    input  c0_data_o, c1_data_o, c0_valid_o, c1_valid_o,
    input  c0_last_o, c1_last_o,
    input  grant_o, busy_o, frame_count_o, drop_count_o,
    input  overrun_o, timeout_o
  );
endinterface

// File: rtl/ram_read_scheduler.sv
// Frame-granular arbiter for the ping-pong RAM read port: grants whole
// frames to c0 (VU meter) or c1 (capture), or flushes unclaimed frames.
// Ports: clk_i, rst_i (sync, active-high), bus (ram_read_scheduler_if.master):
//   RAM side buf_ready_i/ram_data_i/ram_valid_i/ram_ready_o, per-consumer
//   req/data/valid/ready/last, status grant/busy/frame/drop/overrun/timeout.
// Optional stall watchdog: define RAM_SCHED_TIMEOUT_EN.
module ram_read_scheduler #(
  parameter int DATA_W    = 36,
  parameter int FRAME_LEN = 256,
  parameter int TIMEOUT   = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  ram_read_scheduler_if.master bus
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic          gnt_q, gnt_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   frame_q, frame_d;
  logic [7:0]    drop_q, drop_d;

  logic start, xfer, done, to_hit, any_req;

  assign any_req = bus.c0_req_i || bus.c1_req_i;
  assign start   = pend_q || bus.buf_ready_i;
  assign xfer    = bus.ram_valid_i && bus.ram_ready_o;
  assign done    = xfer && (cnt_q == LAST);

`ifdef RAM_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          to_q, to_d;

  // Stall cycles in DRAIN since the last transfer.
  assign to_hit = (state_q == DRAIN) && !xfer
               && (wd_q == WW'(TIMEOUT - 1));

  always_comb begin
    wd_d = '0;
    to_d = to_q || to_hit;
    if (state_q == DRAIN && !xfer) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign bus.timeout_o = to_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign to_hit = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

  // State register and bookkeeping flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = any_req ? DRAIN : FLUSH;
      DRAIN:   if (done) state_d = IDLE;
               else if (to_hit) state_d = FLUSH;
      FLUSH:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, pending, counters.
  always_comb begin
    owner_d = owner_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    pend_d  = pend_q;
    ovr_d   = 1'b0;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    if (state_q == IDLE) begin
      if (start) begin
        // A fresh pulse coinciding with a pending start stays queued.
        pend_d = pend_q && bus.buf_ready_i;
        cnt_d  = '0;
        gnt_d  = any_req;
        unique case (1'b1)
          bus.c0_req_i && bus.c1_req_i:  owner_d = rr_q;
          !bus.c0_req_i && bus.c1_req_i: owner_d = 1'b1;
          default:                       owner_d = 1'b0;
        endcase
      end
    end else begin
      if (bus.buf_ready_i) begin
        if (!pend_q) begin
          pend_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
          if (drop_q != 8'hff) drop_d = drop_q + 8'd1;
        end
      end
      if (xfer) cnt_d = cnt_q + 1'b1;
      if (done) begin
        frame_d = frame_q + 16'd1;
        // Only granted frames move the pointer, flushes do not.
        if (gnt_q) rr_d = ~owner_q;
      end
    end
  end

  // Outputs.
  always_comb begin
    bus.ram_ready_o = 1'b0;
    bus.c0_valid_o  = 1'b0;
    bus.c1_valid_o  = 1'b0;
    bus.c0_data_o   = '0;
    bus.c1_data_o   = '0;
    bus.c0_last_o   = 1'b0;
    bus.c1_last_o   = 1'b0;
    bus.grant_o     = 2'b00;
    unique case (state_q)
      DRAIN: begin
        if (owner_q) begin
          bus.grant_o     = 2'b10;
          bus.c1_valid_o  = bus.ram_valid_i;
          bus.c1_data_o   = bus.ram_data_i;
          bus.c1_last_o   = (cnt_q == LAST);
          bus.ram_ready_o = bus.c1_ready_i;
        end else begin
          bus.grant_o     = 2'b01;
          bus.c0_valid_o  = bus.ram_valid_i;
          bus.c0_data_o   = bus.ram_data_i;
          bus.c0_last_o   = (cnt_q == LAST);
          bus.ram_ready_o = bus.c0_ready_i;
        end
      end
      FLUSH:   bus.ram_ready_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy_o        = (state_q != IDLE);
  assign bus.frame_count_o = frame_q;
  assign bus.drop_count_o  = drop_q;
  assign bus.overrun_o     = ovr_q;
endmodule

// File: tb/tb_ram_read_scheduler.sv
// Bench for ram_read_scheduler: directed frames plus random traffic
// checked against a frame-level reference model.
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))

module tb_ram_read_scheduler;
  localparam int DW = 36;
  localparam int FL = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_read_scheduler_if #(.DATA_W(DW)) bus ();

  ram_read_scheduler #(
    .DATA_W(DW), .FRAME_LEN(FL), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  bit m_rr;
  bit m_pend;
  int m_frames;
  int m_drops;
  logic [DW-1:0] words [FL];

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (bus.grant_o === 2'b11) begin
        errors++;
        $error("FAIL mon_grant_onehot %b", bus.grant_o);
      end
      checks++;
      if ((bus.c0_valid_o && bus.c1_valid_o) !== 1'b0) begin
        errors++;
        $error("FAIL mon_both_valid");
      end
      checks++;
      if (bus.grant_o === 2'b00 &&
          (bus.c0_valid_o | bus.c1_valid_o) !== 1'b0) begin
        errors++;
        $error("FAIL mon_valid_no_grant");
      end
      checks++;
      if (bus.grant_o !== 2'b00 && bus.busy_o !== 1'b1) begin
        errors++;
        $error("FAIL mon_grant_busy");
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_words();
    for (int i = 0; i < FL; i++) begin
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      words[i] = t[DW-1:0];
    end
  endtask

  task automatic do_frame(input bit pulse, input bit r0, input bit r1,
                          input int vpct, input int rpct,
                          input int st_at, input int st_len,
                          input int p1, input int p2, input bit jit);
    bit gr;
    bit own;
    bit ovr_prev;
    logic [1:0] eg;
    int src;
    int n;
    gen_words();
    if (pulse) begin
      bus.c0_req_i    = r0;
      bus.c1_req_i    = r1;
      bus.buf_ready_i = 1'b1;
      bus.ram_valid_i = 1'b0;
      #2;
      `CHK("idle_busy", bus.busy_o, 1'b0);
      step();
      bus.buf_ready_i = 1'b0;
    end else begin
      r0 = bus.c0_req_i;
      r1 = bus.c1_req_i;
    end
    gr  = r0 | r1;
    own = (r0 && r1) ? m_rr : r1;
    eg  = !gr ? 2'b00 : (own ? 2'b10 : 2'b01);
    m_pend = 1'b0;
    src = 0;
    n = 0;
    ovr_prev = 1'b0;
    while (src < FL && n < 200) begin
      bit p;
      bit er;
      bit st;
      p  = (n == p1) || (n == p2);
      st = (n >= st_at) && (n < st_at + st_len);
      bus.buf_ready_i = p;
      bus.ram_valid_i = ($urandom_range(0, 99) < vpct);
      bus.ram_data_i  = words[src];
      bus.c0_ready_i  = ($urandom_range(0, 99) < rpct) && !st;
      bus.c1_ready_i  = ($urandom_range(0, 99) < rpct) && !st;
      if (jit) begin
        bus.c0_req_i = 1'($urandom_range(0, 1));
        bus.c1_req_i = 1'($urandom_range(0, 1));
      end
      #2;
      er = gr ? (own ? bus.c1_ready_i : bus.c0_ready_i) : 1'b1;
      `CHK("busy", bus.busy_o, 1'b1);
      `CHK("grant", bus.grant_o, eg);
      `CHK("ram_ready", bus.ram_ready_o, er);
      `CHK("overrun", bus.overrun_o, ovr_prev);
      `CHK("c0_valid", bus.c0_valid_o, gr && !own && bus.ram_valid_i);
      `CHK("c1_valid", bus.c1_valid_o, gr && own && bus.ram_valid_i);
      if (gr) begin
        `CHK("own_data", own ? bus.c1_data_o : bus.c0_data_o, words[src]);
        `CHK("own_last", own ? bus.c1_last_o : bus.c0_last_o, src == FL - 1);
        `CHK("oth_data", own ? bus.c0_data_o : bus.c1_data_o, 0);
        `CHK("oth_last", own ? bus.c0_last_o : bus.c1_last_o, 1'b0);
      end else begin
        `CHK("flush_last", bus.c0_last_o | bus.c1_last_o, 1'b0);
      end
      ovr_prev = 1'b0;
      if (p) begin
        if (!m_pend) begin
          m_pend = 1'b1;
        end else begin
          ovr_prev = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (bus.ram_valid_i && er) src++;
      n++;
      step();
    end
    `CHK("frame_budget", src, FL);
    if (src == FL) begin
      m_frames = (m_frames + 1) % 65536;
      if (gr) m_rr = !own;
    end
    bus.buf_ready_i = 1'b0;
    bus.ram_valid_i = 1'b0;
    #2;
    `CHK("end_busy", bus.busy_o, 1'b0);
    `CHK("end_grant", bus.grant_o, 2'b00);
    `CHK("end_ram_ready", bus.ram_ready_o, 1'b0);
    `CHK("end_overrun", bus.overrun_o, ovr_prev);
    `CHK("frame_count", bus.frame_count_o, m_frames);
    `CHK("drop_count", bus.drop_count_o, m_drops);
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.buf_ready_i = 1'b1;
    bus.ram_data_i  = '1;
    bus.ram_valid_i = 1'b1;
    bus.c0_req_i    = 1'b1;
    bus.c1_req_i    = 1'b1;
    bus.c0_ready_i  = 1'b1;
    bus.c1_ready_i  = 1'b1;
    m_rr = 1'b0;
    m_pend = 1'b0;
    m_frames = 0;
    m_drops = 0;

    repeat (3) step();
    #2;
    `CHK("rst_grant", bus.grant_o, 2'b00);
    `CHK("rst_busy", bus.busy_o, 1'b0);
    `CHK("rst_ram_ready", bus.ram_ready_o, 1'b0);
    `CHK("rst_c0_valid", bus.c0_valid_o, 1'b0);
    `CHK("rst_c1_valid", bus.c1_valid_o, 1'b0);
    `CHK("rst_last", {bus.c0_last_o, bus.c1_last_o}, 2'b00);
    `CHK("rst_data", bus.c0_data_o | bus.c1_data_o, 0);
    `CHK("rst_frames", bus.frame_count_o, 0);
    `CHK("rst_drops", bus.drop_count_o, 0);
    `CHK("rst_overrun", bus.overrun_o, 1'b0);
    `CHK("rst_timeout", bus.timeout_o, 1'b0);
    step();
    rst = 1'b0;
    bus.buf_ready_i = 1'b0;
    bus.ram_valid_i = 1'b0;
    bus.c0_req_i    = 1'b0;
    bus.c1_req_i    = 1'b0;
    step();
    #2;
    `CHK("post_rst_idle", bus.busy_o, 1'b0);
    step();

    do_frame(1, 0, 1, 100, 100, -1, 0, -1, -1, 0);
    repeat (4) do_frame(1, 1, 1, 80, 80, -1, 0, -1, -1, 0);
    do_frame(1, 0, 0, 100, 100, -1, 0, -1, -1, 0);
    do_frame(1, 1, 0, 100, 100, 3, 5, -1, -1, 0);
    do_frame(1, 1, 1, 100, 100, -1, 0, 2, 4, 0);
    do_frame(0, 1, 1, 100, 100, -1, 0, -1, -1, 0);

    gen_words();
    bus.c0_req_i = 1'b1;
    bus.c1_req_i = 1'b0;
    bus.buf_ready_i = 1'b1;
    step();
    bus.buf_ready_i = 1'b0;
    bus.ram_valid_i = 1'b1;
    bus.c0_ready_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ram_data_i = words[i];
      step();
    end
    rst = 1'b1;
    bus.ram_valid_i = 1'b0;
    step();
    rst = 1'b0;
    #2;
    `CHK("mid_rst_busy", bus.busy_o, 1'b0);
    `CHK("mid_rst_grant", bus.grant_o, 2'b00);
    `CHK("mid_rst_frames", bus.frame_count_o, 0);
    `CHK("mid_rst_drops", bus.drop_count_o, 0);
    step();
    m_rr = 1'b0;
    m_pend = 1'b0;
    m_frames = 0;
    m_drops = 0;
    do_frame(1, 1, 1, 100, 100, -1, 0, -1, -1, 0);

    for (int k = 0; k < 20; k++) begin
      bit r0;
      bit r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      do_frame(!m_pend, r0, r1, 80, 80, -1, 0,
               int'($urandom_range(0, 15)), int'($urandom_range(0, 30)),
               1'($urandom_range(0, 1)));
    end
    if (m_pend) do_frame(0, 0, 0, 80, 80, -1, 0, -1, -1, 0);

`ifdef RAM_SCHED_TIMEOUT_EN
    begin
      int src;
      gen_words();
      bus.c0_req_i = 1'b1;
      bus.c1_req_i = 1'b0;
      bus.buf_ready_i = 1'b1;
      bus.ram_valid_i = 1'b0;
      step();
      bus.buf_ready_i = 1'b0;
      bus.ram_valid_i = 1'b1;
      bus.c0_ready_i  = 1'b1;
      src = 0;
      for (int i = 0; i < 4; i++) begin
        bus.ram_data_i = words[src];
        #2;
        `CHK("wd_data", bus.c0_data_o, words[src]);
        step();
        src++;
      end
      bus.c0_ready_i = 1'b0;
      for (int s = 1; s <= TO; s++) begin
        bus.ram_data_i = words[src];
        #2;
        `CHK("wd_stall_ready", bus.ram_ready_o, 1'b0);
        `CHK("wd_pre_timeout", bus.timeout_o, 1'b0);
        step();
      end
      for (int i = 0; i < 4; i++) begin
        bus.ram_data_i = words[src];
        #2;
        `CHK("wd_timeout", bus.timeout_o, 1'b1);
        `CHK("wd_flush_ready", bus.ram_ready_o, 1'b1);
        `CHK("wd_flush_valid", bus.c0_valid_o, 1'b0);
        `CHK("wd_flush_grant", bus.grant_o, 2'b00);
        step();
        src++;
      end
      bus.ram_valid_i = 1'b0;
      m_frames++;
      m_rr = 1'b1;
      #2;
      `CHK("wd_end_busy", bus.busy_o, 1'b0);
      `CHK("wd_frames", bus.frame_count_o, m_frames);
      step();
      do_frame(1, 1, 1, 100, 100, -1, 0, -1, -1, 0);
      `CHK("wd_sticky", bus.timeout_o, 1'b1);
    end
`else
    `CHK("timeout_tied", bus.timeout_o, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_read_scheduler.md
# ram_read_scheduler

Frame-granular arbiter and sequencer for the RAM ping-pong buffer read port. On each buffer-swap pulse it grants one whole frame of RAM reads to one of two consumers (consumer 0: VU meter, consumer 1: parallel readout/capture port), passing the valid/ready handshake through. When neither consumer is requesting, it drains and discards the frame so the buffer never stalls. It sits between the RAM buffer's read side and its consumers, replacing the fixed single-consumer hookup.

## Interface
Parameters:
- DATA_W, 36: RAM word width.
- FRAME_LEN, 256: words per buffer half (≥2).
- TIMEOUT, 1023: stall-watchdog limit in cycles (used only with the watchdog compiled in).

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- buf_ready_i  in  1  one-cycle pulse: a new frame is readable.
- ram_data_i  in  DATA_W  RAM read data.
- ram_valid_i  in  1  RAM read data valid.
- ram_ready_o  out  1  read-accept to the RAM.
- c0_req_i, c1_req_i  in  1 each  consumer wants frames (level).
- c0_data_o, c1_data_o  out  DATA_W each  routed data.
- c0_valid_o, c1_valid_o  out  1 each  routed valid.
- c0_ready_i, c1_ready_i  in  1 each  consumer ready.
- c0_last_o, c1_last_o  out  1 each  marks the final word of the frame.
- grant_o  out  2  one-hot current owner; 00 when not granted.
- busy_o  out  1  high in DRAIN or FLUSH.
- frame_count_o  out  16  completed frames (granted and flushed); wraps.
- drop_count_o  out  8  frames lost to overrun; saturates at 255.
- overrun_o  out  1  one-cycle pulse on each dropped buf_ready_i.
- timeout_o  out  1  sticky; set on watchdog expiry; cleared only by reset.

## Operation
- States: IDLE, DRAIN, FLUSH.
- Pending flag: set by buf_ready_i (or by the "start" condition in IDLE), cleared when a frame starts.
- IDLE with pending or buf_ready_i:
  - If any request is high, go to DRAIN. Grant the requesting consumer; if both request, grant by round-robin.
  - Otherwise go to FLUSH.
- Round-robin pointer:
  - After reset it favours c0.
  - It toggles to the other consumer after each granted frame completes.
  - It does not change after a FLUSH.
- DRAIN (owner k):
  - Drive ck_valid_o = ram_valid_i, ck_data_o = ram_data_i, ram_ready_o = ck_ready_i.
  - The non-owner sees valid = 0, last = 0, data = 0.
- FLUSH: ram_ready_o = 1; all consumer valid outputs are 0.
- Word counter: increments on ram_valid_i && ram_ready_o.
  - ck_last_o is high while the counter equals FRAME_LEN-1.
  - The transfer at that count ends the frame: frame_count_o increments, then IDLE.
- Requests are sampled only at grant. Dropping a request mid-frame does not revoke the grant.
- buf_ready_i while in DRAIN/FLUSH:
  - If pending is clear, set pending; no drop.
  - If pending is already set, pulse overrun_o and increment drop_count_o.
- Arithmetic:
  - Word counter width is $clog2(FRAME_LEN).
  - frame_count_o wraps modulo 2^16.
  - drop_count_o saturates at 255.

## Timing
- Reset: all outputs are 0; state is IDLE; pending is 0; the round-robin pointer points at c0.
- Grant latency: buf_ready_i at cycle N gives grant_o/busy_o high at N+1. The first word can transfer at N+1.
- Data path in DRAIN is combinational pass-through: 0-cycle latency, no buffering.
- Back-to-back frames: if pending is set when the last word transfers, the next cycle is IDLE. The new grant follows one cycle later, so there is a 1-cycle bubble.
- Simultaneous events:
  - buf_ready_i in the same cycle as the final transfer sets pending (no drop).
  - Both requests rising in the same cycle as the grant decision resolve by the pointer.
- Reset mid-frame: returns to IDLE next cycle. The partial frame is not counted; counters clear.

## Configuration
- RAM_SCHED_TIMEOUT_EN, when defined, compiles in the stall watchdog:
  - A counter clears on each transfer and increments every cycle in DRAIN.
  - Reaching TIMEOUT sets timeout_o and switches to FLUSH for the remaining words. The frame still counts.
- Without the macro: no watchdog logic; timeout_o is tied to 0; DRAIN waits indefinitely.

## Test plan
- Only c1_req_i = 1, FRAME_LEN = 8, RAM streams 0..7 with ram_valid_i always high:
  - c1 receives 0..7, with c1_last_o on word 7.
  - grant_o = 10 from the cycle after buf_ready_i.
  - frame_count_o = 1; c0_valid_o stays 0.
- Both requests high, 4 frames: grants are c0, c1, c0, c1; frame_count_o = 4.
- No requests, buf_ready_i: FLUSH with ram_ready_o = 1 for 8 transfers; no consumer valid; frame_count_o = 1.
- c0 owner holds c0_ready_i = 0 for 5 cycles mid-frame: ram_ready_o = 0 during those cycles; no word lost or duplicated.
- Three buf_ready_i pulses within one frame:
  - First pulse starts the frame; second sets pending; third pulses overrun_o once, giving drop_count_o = 1.
  - The pending frame starts after the 1-cycle IDLE bubble.
- With RAM_SCHED_TIMEOUT_EN, TIMEOUT = 16, consumer stalled forever after word 3:
  - timeout_o sets at the 16th stall cycle.
  - The remaining 4 words are flushed; the next buf_ready_i is granted normally.
